alu_seq: RTL and testbench

//  Parametrised, handshaked, registered ALU; successor to the 4-bit combinational ALU.

---
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_alu_seq.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/response bundle between issue logic and the sequential ALU
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             flag;
    logic             err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, carry, overflow, flag, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, carry, overflow, flag, err
    );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked registered ALU, iterative shifts; multiply enabled by ALU_SEQ_MUL_EN
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_NOT = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SLT = 4'b0110;
    localparam logic [3:0] OP_EQ  = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1011;
`endif

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             flag_q, flag_d;
    logic             err_q, err_d;
`ifdef ALU_SEQ_MUL_EN
    // acc holds the running high half, mlo the multiplier shifting into the low half
    logic [WIDTH-1:0] mlo_q, mlo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
`endif

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic             c, v, f, e, fin;
    logic [WIDTH-1:0] step_acc;
    logic             step_last;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        flag_d     = flag_q;
        err_d      = err_q;
`ifdef ALU_SEQ_MUL_EN
        mlo_d      = mlo_q;
        mcand_d    = mcand_q;
`endif
        sum        = '0;
        r          = '0;
        c          = 1'b0;
        v          = 1'b0;
        f          = 1'b0;
        e          = 1'b0;
        fin        = 1'b0;
        step_acc   = acc_q;
        step_last  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d  = bus.op;
                    acc_d = bus.a;
                    cnt_d = {1'b0, bus.b[SHW-1:0]};
                    case (bus.op)
                        OP_ADD: begin
                            sum = {1'b0, bus.a} + {1'b0, bus.b};
                            r   = sum[WIDTH-1:0];
                            c   = sum[WIDTH];
                            v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (r[WIDTH-1] != bus.a[WIDTH-1]);
                            fin = 1'b1;
                        end
                        OP_SUB: begin
                            sum = {1'b0, bus.a} - {1'b0, bus.b};
                            r   = sum[WIDTH-1:0];
                            c   = sum[WIDTH];
                            v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (r[WIDTH-1] != bus.a[WIDTH-1]);
                            fin = 1'b1;
                        end
                        OP_NOT: begin r = ~bus.a;         fin = 1'b1; end
                        OP_AND: begin r = bus.a & bus.b;  fin = 1'b1; end
                        OP_OR:  begin r = bus.a | bus.b;  fin = 1'b1; end
                        OP_XOR: begin r = bus.a ^ bus.b;  fin = 1'b1; end
                        OP_SLT: begin
                            f   = $signed(bus.a) < $signed(bus.b);
                            r   = {{(WIDTH-1){1'b0}}, f};
                            fin = 1'b1;
                        end
                        OP_EQ: begin
                            f   = (bus.a == bus.b);
                            r   = {{(WIDTH-1){1'b0}}, f};
                            fin = 1'b1;
                        end
                        OP_SLL, OP_SRL, OP_SRA: begin
                            if (bus.b[SHW-1:0] == '0) begin
                                r   = bus.a;
                                fin = 1'b1;
                            end else begin
                                state_d = S_BUSY;
                            end
                        end
`ifdef ALU_SEQ_MUL_EN
                        OP_MUL: begin
                            acc_d   = '0;
                            mlo_d   = bus.b;
                            mcand_d = bus.a;
                            cnt_d   = CW'(WIDTH);
                            state_d = S_BUSY;
                        end
`endif
                        default: begin
                            e   = 1'b1;
                            fin = 1'b1;
                        end
                    endcase
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                case (op_q)
                    OP_SLL: begin
                        step_acc  = {acc_q[WIDTH-2:0], 1'b0};
                        step_last = acc_q[WIDTH-1];
                    end
                    OP_SRL: begin
                        step_acc  = {1'b0, acc_q[WIDTH-1:1]};
                        step_last = acc_q[0];
                    end
                    OP_SRA: begin
                        step_acc  = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
                        step_last = acc_q[0];
                    end
`ifdef ALU_SEQ_MUL_EN
                    OP_MUL: begin
                        sum      = {1'b0, acc_q} + (mlo_q[0] ? {1'b0, mcand_q} : '0);
                        step_acc = sum[WIDTH:1];
                        mlo_d    = {sum[0], mlo_q[WIDTH-1:1]};
                    end
`endif
                    default: ;
                endcase
                acc_d = step_acc;
                if (cnt_q == CW'(1)) begin
                    fin = 1'b1;
                    r   = step_acc;
                    c   = step_last;
`ifdef ALU_SEQ_MUL_EN
                    if (op_q == OP_MUL) begin
                        r = mlo_d;
                        c = |step_acc;
                    end
`endif
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fin) begin
            state_d    = S_DONE;
            result_d   = r;
            zero_d     = !e && (r == '0);
            carry_d    = c;
            overflow_d = v;
            flag_d     = f;
            err_d      = e;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            flag_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mlo_q      <= '0;
            mcand_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            flag_q     <= flag_d;
            err_q      <= err_d;
`ifdef ALU_SEQ_MUL_EN
            mlo_q      <= mlo_d;
            mcand_q    <= mcand_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.flag      = flag_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - bench for alu_seq: vector table, corner sequences, random ops vs arithmetic model
module tb_alu_seq;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] result;
        logic [4:0]  flags;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  flags;
        int          lat;
    } exp_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [4:0] flags_now();
        return {bus.zero, bus.carry, bus.overflow, bus.flag, bus.err};
    endfunction

    // flags packed as {zero, carry, overflow, flag, err}
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t            ex;
        longint          sa, sb, sr;
        longint unsigned ua, ub, ur;
        int              s;
        logic [31:0]     r;
        logic            c, v, f, er;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        s  = int'(b[4:0]);
        r  = '0; c = 0; v = 0; f = 0; er = 0;
        ex.lat = 1;
        case (op)
            4'd0: begin ur = ua + ub; r = ur[31:0]; c = ur[32]; sr = sa + sb; v = (sr != longint'($signed(r))); end
            4'd1: begin ur = ua - ub; r = ur[31:0]; c = (ua < ub); sr = sa - sb; v = (sr != longint'($signed(r))); end
            4'd2: r = ~a;
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            4'd6: begin f = (sa < sb); r = {31'b0, f}; end
            4'd7: begin f = (a == b); r = {31'b0, f}; end
            4'd8: begin r = a << s; c = (s != 0) ? a[32-s] : 1'b0; ex.lat = 1 + s; end
            4'd9: begin r = a >> s; c = (s != 0) ? a[s-1] : 1'b0; ex.lat = 1 + s; end
            4'd10: begin r = 32'($signed(a) >>> s); c = (s != 0) ? a[s-1] : 1'b0; ex.lat = 1 + s; end
`ifdef ALU_SEQ_MUL_EN
            4'd11: begin ur = ua * ub; r = ur[31:0]; c = (ur[63:32] != 0); ex.lat = 33; end
`endif
            default: er = 1'b1;
        endcase
        ex.result = r;
        ex.flags  = {(!er && r == 0), c, v, f, er};
        return ex;
    endfunction

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input logic [4:0] exp_f, input int exp_lat,
                         input string tag);
        int lat;
        bit rdy_bad;
        rdy_bad = 0;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op       = 4'($urandom_range(0, 15));
        bus.a        = $urandom;
        bus.b        = $urandom;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) rdy_bad = 1;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.in_ready) rdy_bad = 1;
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        if (!bus.out_valid) begin
            @(negedge clk); rst = 1'b1;
            @(negedge clk); rst = 1'b0;
            return;
        end
        chk({tag, " result"}, bus.result, exp_r);
        chk({tag, " flags"}, 32'(flags_now()), 32'(exp_f));
        chk({tag, " in_ready busy"}, 32'(rdy_bad), 32'd0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, " out_valid after hs"}, 32'(bus.out_valid), 32'd0);
        chk({tag, " in_ready after hs"}, 32'(bus.in_ready), 32'd1);
        chk({tag, " result hold"}, bus.result, exp_r);
    endtask

    initial begin
        exp_t ex;
        bit   stable_bad;
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        tbl.push_back('{4'h0, 32'hFFFF_FFFF, 32'h1,         32'h0,         5'b11000, 1});
        tbl.push_back('{4'h1, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 5'b00100, 1});
        tbl.push_back('{4'h6, 32'hFFFF_FFFF, 32'h0,         32'h1,         5'b00010, 1});
        tbl.push_back('{4'h6, 32'h0,         32'hFFFF_FFFF, 32'h0,         5'b10000, 1});
        tbl.push_back('{4'hA, 32'h8000_0000, 32'h4,         32'hF800_0000, 5'b00000, 5});
        tbl.push_back('{4'h1, 32'h1,         32'h2,         32'hFFFF_FFFF, 5'b01000, 1});
        tbl.push_back('{4'h0, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 5'b00100, 1});
        tbl.push_back('{4'h7, 32'h5,         32'h5,         32'h1,         5'b00010, 1});
        tbl.push_back('{4'h7, 32'h5,         32'h6,         32'h0,         5'b10000, 1});
        tbl.push_back('{4'h9, 32'h3,         32'h1,         32'h1,         5'b01000, 2});
        tbl.push_back('{4'h8, 32'h8000_0001, 32'h1,         32'h2,         5'b01000, 2});
        tbl.push_back('{4'h8, 32'h1234,      32'h20,        32'h1234,      5'b00000, 1});
        tbl.push_back('{4'hA, 32'h4000_0000, 32'h1F,        32'h0,         5'b11000, 32});
        tbl.push_back('{4'h2, 32'hFFFF_FFFF, 32'h0,         32'h0,         5'b10000, 1});
        tbl.push_back('{4'h3, 32'hF0F0,      32'hFF00,      32'hF000,      5'b00000, 1});
        tbl.push_back('{4'h4, 32'h0F,        32'hF0,        32'hFF,        5'b00000, 1});
        tbl.push_back('{4'h5, 32'hAAAA_5555, 32'hAAAA_5555, 32'h0,         5'b10000, 1});
        tbl.push_back('{4'hC, 32'h5,         32'h7,         32'h0,         5'b00001, 1});
        tbl.push_back('{4'hF, 32'h0,         32'h0,         32'h0,         5'b00001, 1});
`ifdef ALU_SEQ_MUL_EN
        tbl.push_back('{4'hB, 32'h3,         32'h5,         32'd15,        5'b00000, 33});
`else
        tbl.push_back('{4'hB, 32'h3,         32'h5,         32'h0,         5'b00001, 1});
`endif

        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = 4'h0;
        bus.a         = 32'h1;
        bus.b         = 32'h1;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("out_valid during rst", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        @(posedge clk); #1;
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset result", bus.result, 32'd0);
        chk("reset flags", 32'(flags_now()), 32'd0);

        // result held while consumer stalls; requests in DONE are not taken
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 4'h0; bus.a = 32'd2; bus.b = 32'd3;
        @(posedge clk); #1;
        chk("hold first out_valid", 32'(bus.out_valid), 32'd1);
        chk("hold first result", bus.result, 32'd5);
        bus.op = 4'h1; bus.a = 32'd9; bus.b = 32'd1;
        stable_bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (!bus.out_valid || bus.result !== 32'd5 || bus.in_ready) stable_bad = 1;
        end
        chk("hold stable", 32'(stable_bad), 32'd0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("hold release in_ready", 32'(bus.in_ready), 32'd1);
        chk("hold release out_valid", 32'(bus.out_valid), 32'd0);
        chk("hold release result", bus.result, 32'd5);

        // reset in the middle of a long shift
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 4'h8; bus.a = 32'h1; bus.b = 32'd20;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midshift rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("midshift rst result", bus.result, 32'd0);
        chk("midshift rst in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].result, tbl[i].flags, tbl[i].lat,
                  $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 150; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) rb = ra;
            ex = model(rop, ra, rb);
            do_op(rop, ra, rb, ex.result, ex.flags, ex.lat,
                  $sformatf("rnd%0d op%0h a%0h b%0h", i, rop, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
